// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared sizing constants for the FIFO-to-stream read path
package fifo_rd_pkg;
  localparam int DATA_W_DEFAULT = 8;
  localparam int BUF_DEPTH      = 2;
  localparam int CNT_W          = 16;

  typedef logic [1:0] buf_cnt_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry output buffer; head and valid are flops so the
// stream side has no combinational path from the capture data.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output buf_cnt_t          cnt
);

  logic [DATA_W-1:0] tail;
  logic [DATA_W-1:0] head_nxt;
  logic [DATA_W-1:0] tail_nxt;
  buf_cnt_t          cnt_nxt;

  always_comb begin
    cnt_nxt  = cnt;
    head_nxt = head;
    tail_nxt = tail;
    if (flush) begin
      cnt_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head_nxt = data;
          else             tail_nxt = data;
          cnt_nxt = cnt + 2'd1;
        end
        2'b01: begin
          head_nxt = tail;
          cnt_nxt  = cnt - 2'd1;
        end
        2'b11: begin
          // a single entry leaves and is replaced; two entries shift then refill
          if (cnt == 2'd1) begin
            head_nxt = data;
          end else begin
            head_nxt = tail;
            tail_nxt = data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt   <= '0;
      valid <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else begin
      cnt   <= cnt_nxt;
      valid <= (cnt_nxt != 2'd0);
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - issues FIFO reads and presents them as a valid/ready stream.
// Optional macro FIFO_RD_CNT_EN adds the rd_count transfer counter port.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              en,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0]  rd_count
`endif
);

  buf_cnt_t   buf_cnt;
  logic       inflight;
  logic       pop;
  logic [2:0] occ;

  assign pop = m_valid && m_ready;

  // Occupancy seen by the next capture: buffered + returning - leaving this cycle.
  assign occ        = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = rstN && en && !fifo_empty && !flush && (occ < 3'(BUF_DEPTH));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) inflight <= 1'b0;
    else       inflight <= fifo_rd_en;
  end

  fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rstN  (rstN),
    .push  (inflight && !flush),
    .pop   (pop),
    .flush (flush),
    .data  (fifo_rd_data),
    .head  (m_data),
    .valid (m_valid),
    .cnt   (buf_cnt)
  );

`ifdef FIFO_RD_CNT_EN
  // Flush does not clear the count: it tracks completed transfers only.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)    rd_count <= '0;
    else if (pop) rd_count <= rd_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - bench for fifo_rd_stream with a queue-based FIFO and stream model.
// Build with or without FIFO_RD_CNT_EN; rd_count is checked when the macro is defined.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rstN;
  logic       en;
  logic       flush;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_count;
`endif

  fifo_rd_stream #(.DATA_W(8)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .en           (en),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count     (rd_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         t;
  } word_t;

  word_t       exp_q[$];
  logic [7:0]  fifo_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  sent_q[$];
  int          pop_cyc_q[$];
  int          rd_cyc_q[$];
  int          cyc;
  int          v_cnt;
  int          n_vec;
  int          n_fail;
  logic [15:0] pops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: check and advance the model at the falling edge, then act as the FIFO.
  task automatic step();
    bit         exp_v;
    bit         exp_rd;
    bit         pop_m;
    bit         rd;
    logic [7:0] rd_word;
    exp_v   = 1'b0;
    exp_rd  = 1'b0;
    pop_m   = 1'b0;
    rd_word = 8'($urandom);
    @(negedge clk);
    cyc++;
    if (!rstN) begin
      exp_q.delete();
      pops = '0;
      check("m_data_rst", 32'(m_data), 32'h0);
    end else begin
      exp_v  = (exp_q.size() > 0) && (exp_q[0].t + 2 <= cyc);
      pop_m  = exp_v && m_ready;
      exp_rd = en && !fifo_empty && !flush && ((exp_q.size() - int'(pop_m)) < 2);
    end
    check("m_valid", 32'(m_valid), 32'(exp_v));
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    if (exp_v) check("m_data", 32'(m_data), 32'(exp_q[0].d));
`ifdef FIFO_RD_CNT_EN
    check("rd_count", 32'(rd_count), 32'(pops));
`endif
    if (m_valid) v_cnt++;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      pop_cyc_q.push_back(cyc);
    end
    if (pop_m) begin
      void'(exp_q.pop_front());
      pops = pops + 16'd1;
    end
    if (rstN && flush) exp_q.delete();
    rd = fifo_rd_en && (fifo_q.size() > 0);
    if (rd) begin
      rd_word = fifo_q.pop_front();
      rd_cyc_q.push_back(cyc);
      if (rstN) exp_q.push_back('{d: rd_word, t: cyc});
    end
    @(posedge clk);
    #1;
    fifo_rd_data = rd_word;
    fifo_empty   = (fifo_q.size() == 0);
  endtask

  task automatic idle(input int n);
    en      = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    logic [7:0] exp4[4];
    logic [7:0] w;
    exp4  = '{8'h11, 8'h22, 8'h33, 8'h44};
    n_vec = 0; n_fail = 0; cyc = 0; v_cnt = 0; pops = '0;
    rstN = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = 8'h00;
    repeat (3) step();
    rstN = 1'b1;
    idle(2);

    // Preloaded FIFO, sink always ready: back-to-back delivery after 2-cycle latency
    foreach (exp4[i]) load(exp4[i]);
    got_q.delete(); pop_cyc_q.delete(); rd_cyc_q.delete();
    en = 1'b1;
    repeat (8) step();
    check("t1_count", 32'(got_q.size()), 32'd4);
    foreach (exp4[i]) if (i < got_q.size()) check("t1_data", 32'(got_q[i]), 32'(exp4[i]));
    if (pop_cyc_q.size() == 4) check("t1_consecutive", 32'(pop_cyc_q[3] - pop_cyc_q[0]), 32'd3);
    if (pop_cyc_q.size() > 0 && rd_cyc_q.size() > 0)
      check("t1_latency", 32'(pop_cyc_q[0] - rd_cyc_q[0]), 32'd2);
`ifdef FIFO_RD_CNT_EN
    check("t1_rd_count", 32'(rd_count), 32'd4);
`endif
    idle(4);

    // Sink stalled: only two reads issue, head stays on the first word
    foreach (exp4[i]) load(exp4[i]);
    rd_cyc_q.delete();
    m_ready = 1'b0; en = 1'b1;
    repeat (10) step();
    check("t2_rd_pulses", 32'(rd_cyc_q.size()), 32'd2);
    check("t2_head", 32'(m_data), 32'h11);
    got_q.delete();
    m_ready = 1'b1;
    repeat (8) step();
    check("t2_count", 32'(got_q.size()), 32'd4);
    foreach (exp4[i]) if (i < got_q.size()) check("t2_data", 32'(got_q[i]), 32'(exp4[i]));
    idle(4);

    // Empty FIFO with reads enabled: nothing happens
    rd_cyc_q.delete(); v_cnt = 0;
    en = 1'b1;
    repeat (20) step();
    check("t3_rd_pulses", 32'(rd_cyc_q.size()), 32'd0);
    check("t3_valid_cycles", 32'(v_cnt), 32'd0);
    idle(2);

    // Flush with one word buffered and one returning: both dropped
    for (int i = 1; i <= 4; i++) load(8'(8'hA0 + i));
    m_ready = 1'b0; en = 1'b1;
    repeat (2) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_valid_after_flush", 32'(m_valid), 32'd0);
    got_q.delete();
    m_ready = 1'b1;
    repeat (6) step();
    check("t4_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() > 1) begin
      check("t4_first", 32'(got_q[0]), 32'hA3);
      check("t4_second", 32'(got_q[1]), 32'hA4);
    end
    idle(4);

    // Sink toggling ready against a full FIFO
    sent_q.delete(); got_q.delete();
    for (int i = 0; i < 16; i++) begin
      w = 8'($urandom);
      sent_q.push_back(w);
      load(w);
    end
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      m_ready = ~m_ready;
      step();
    end
    m_ready = 1'b1;
    repeat (10) step();
    check("t5_count", 32'(got_q.size()), 32'd16);
    foreach (sent_q[i]) if (i < got_q.size()) check("t5_data", 32'(got_q[i]), 32'(sent_q[i]));
    idle(4);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) load(8'($urandom));
    en = 1'b1; m_ready = 1'b1;
    repeat (4) step();
    check("t6_valid_before", 32'(m_valid), 32'd1);
    #1 rstN = 1'b0;
    #1;
    check("t6_valid_async", 32'(m_valid), 32'd0);
    check("t6_rd_en_async", 32'(fifo_rd_en), 32'd0);
`ifdef FIFO_RD_CNT_EN
    check("t6_rd_count_async", 32'(rd_count), 32'd0);
`endif
    repeat (2) step();
    rstN = 1'b1;
    repeat (10) step();
    idle(4);

    // Random traffic: enable, ready, flush and FIFO fill all vary
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(3) != 0);
      m_ready = $urandom_range(1);
      flush   = ($urandom_range(31) == 0);
      if (fifo_q.size() < 8 && $urandom_range(1) == 1) load(8'($urandom));
      step();
    end
    flush = 1'b0; en = 1'b1; m_ready = 1'b1;
    repeat (30) step();
    check("final_fifo_drained", 32'(fifo_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
